capture_assembler: RTL and testbench

//  Upstream feeder for the RAM file-loading stage. Packs an 8-bit captured byte stream into
//  16-bit words and buffers them in a small FIFO. Presents each word with its RAM address
//  (base + index) as captured_data/ramBase plus a one-cycle load strobe. Signals done after the

---
 rtl/capture_pkg.sv | 7 +
 rtl/word_fifo.sv | 35 +++
 rtl/capture_assembler.sv | 109 ++++++++++
 tb/tb_capture_assembler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and default widths for the capture assembler
package capture_pkg;
    localparam int BYTE_W = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: synchronous FIFO with full/empty flags and concurrent push/pop
module word_fifo
    import capture_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/capture_assembler.sv
// capture_assembler: packs captured bytes into words, buffers them and hands them off with RAM addresses
module capture_assembler #(
    parameter int BYTE_W     = capture_pkg::BYTE_W,
    parameter int DATA_W     = capture_pkg::DATA_W,
    parameter int ADDR_W     = capture_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              out_ready,
    output logic              load,
    output logic [DATA_W-1:0] captured_data,
    output logic [ADDR_W-1:0] ramBase,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    import capture_pkg::*;
    state_t state;
    logic [ADDR_W-1:0] base, pop_idx;
    logic [15:0] count, pushed;
    logic phase;
    logic [BYTE_W-1:0] held;
    logic [DATA_W-1:0] word, fifo_dout, pop_data;
    logic full, empty, accept, push_word, pop, fifo_push, fifo_pop;
    assign byte_ready = (state == CAPTURE) && !full && (pushed < count);
    assign accept     = byte_valid && byte_ready;
    assign push_word  = accept && phase;
    assign word       = (BIG_ENDIAN != 0) ? {held, byte_in} : {byte_in, held};
    // An empty FIFO is bypassed so a freshly completed word loads on the very next cycle.
    assign pop        = (!empty || push_word) && out_ready && !load;
    assign fifo_push  = push_word && !(empty && pop);
    assign fifo_pop   = pop && !empty;
    assign pop_data   = empty ? word : fifo_dout;
    word_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .push  (fifo_push),
        .din   (word),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (RST) begin
            state         <= IDLE;
            base          <= '0;
            count         <= '0;
            pushed        <= '0;
            pop_idx       <= '0;
            phase         <= 1'b0;
            held          <= '0;
            load          <= 1'b0;
            captured_data <= '0;
            ramBase       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            load <= pop;
            if (pop) begin
                captured_data <= pop_data;
                ramBase       <= base + pop_idx;
                pop_idx       <= pop_idx + 1'b1;
            end
            if (accept) begin
                phase <= !phase;
                held  <= byte_in;
            end
            if (push_word) pushed <= pushed + 1'b1;
            if (state == CAPTURE && byte_valid && !byte_ready) overflow <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    overflow <= 1'b0;
                    if (word_count != '0) begin
                        base    <= base_addr;
                        count   <= word_count;
                        pushed  <= '0;
                        pop_idx <= '0;
                        phase   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CAPTURE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                CAPTURE: if (pushed == count) state <= DRAIN;
                DRAIN: if (empty && !load) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_assembler.sv
// tb_capture_assembler: big- and little-endian instances driven together, checked against a word scoreboard
module tb_capture_assembler;
    logic clk = 1'b0, RST = 1'b1, start = 1'b0, byte_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] base_addr = '0, word_count = '0;
    logic [7:0] byte_in = '0;
    logic byte_ready_b, load_b, busy_b, done_b, ovf_b;
    logic byte_ready_l, load_l, busy_l, done_l, ovf_l;
    logic [15:0] data_b, ram_b, data_l, ram_l;
    typedef struct {logic [15:0] be; logic [15:0] le; logic [15:0] addr;} exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0, loads = 0, loads_before = 0;
    logic prev_load = 1'b0;
    exp_t e;

    capture_assembler #(.BIG_ENDIAN(1)) dut_be (
        .clk(clk), .RST(RST), .start(start), .base_addr(base_addr), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_b), .out_ready(out_ready),
        .load(load_b), .captured_data(data_b), .ramBase(ram_b), .busy(busy_b), .done(done_b),
        .overflow(ovf_b)
    );
    capture_assembler #(.BIG_ENDIAN(0)) dut_le (
        .clk(clk), .RST(RST), .start(start), .base_addr(base_addr), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_l), .out_ready(out_ready),
        .load(load_l), .captured_data(data_l), .ramBase(ram_l), .busy(busy_l), .done(done_l),
        .overflow(ovf_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] addr);
        q.push_back('{be: {b0, b1}, le: {b1, b0}, addr: addr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] base, input logic [15:0] cnt);
        base_addr = base;
        word_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_honour(input logic [7:0] b);
        int n = 0;
        while (!byte_ready_b && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) chk("ready_timeout", byte_ready_b, 1);
        send_raw(b);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_b && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_done"}, {done_b, done_l}, 2'b11);
        chk({name, "_busy_low"}, {busy_b, busy_l}, 2'b00);
        chk({name, "_all_loaded"}, q.size(), 0);
        tick();
        chk({name, "_done_one_cycle"}, {done_b, done_l}, 2'b00);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_be"}, {load_b, busy_b, done_b, ovf_b, byte_ready_b, data_b, ram_b}, 0);
        chk({name, "_le"}, {load_l, busy_l, done_l, ovf_l, byte_ready_l, data_l, ram_l}, 0);
    endtask

    always @(negedge clk) begin
        if (RST) begin
            prev_load = 1'b0;
        end else begin
            if (load_b || load_l) begin
                chk("load_spacing", prev_load, 1'b0);
                if (q.size() == 0) begin
                    chk("unexpected_load", {load_b, load_l}, 2'b00);
                end else begin
                    e = q.pop_front();
                    loads++;
                    chk("load_both", {load_b, load_l}, 2'b11);
                    chk("data_be", data_b, e.be);
                    chk("data_le", data_l, e.le);
                    chk("ram_be", ram_b, e.addr);
                    chk("ram_le", ram_l, e.addr);
                end
            end
            if (done_b) chk("busy_with_done", busy_b, 1'b0);
            prev_load = load_b;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk_zero("reset_outputs");
        RST = 1'b0;
        tick();
        // 1 and 2: big/little endian packing, addresses from base
        go(16'h0100, 16'd2);
        chk("busy_after_start", {busy_b, busy_l}, 2'b11);
        q.push_back('{be: 16'h1234, le: 16'h3412, addr: 16'h0100});
        q.push_back('{be: 16'h5678, le: 16'h7856, addr: 16'h0101});
        send_honour(8'h12);
        send_honour(8'h34);
        send_honour(8'h56);
        send_honour(8'h78);
        wait_done("t1");
        chk("t1_no_overflow", {ovf_b, ovf_l}, 2'b00);
        // 3: zero count completes immediately with no load
        go(16'h0700, 16'd0);
        chk("t3_done", {done_b, done_l, busy_b}, 3'b110);
        tick();
        chk("t3_done_pulse", {done_b, done_l}, 2'b00);
        // 4: address wrap
        go(16'hFFFF, 16'd2);
        q.push_back('{be: 16'h9ABC, le: 16'hBC9A, addr: 16'hFFFF});
        q.push_back('{be: 16'hDEF0, le: 16'hF0DE, addr: 16'h0000});
        send_honour(8'h9A);
        send_honour(8'hBC);
        send_honour(8'hDE);
        send_honour(8'hF0);
        wait_done("t4");
        // 5: backpressure, source honours byte_ready
        out_ready = 1'b0;
        loads_before = loads;
        go(16'h0200, 16'd6);
        for (int w = 0; w < 6; w++) expect_word(8'h10 + 8'(2 * w), 8'h11 + 8'(2 * w), 16'h0200 + 16'(w));
        for (int i = 0; i < 8; i++) send_honour(8'h10 + 8'(i));
        repeat (3) begin
            tick();
            chk("t5_ready_low_when_full", {byte_ready_b, byte_ready_l}, 2'b00);
        end
        out_ready = 1'b1;
        for (int i = 8; i < 12; i++) send_honour(8'h10 + 8'(i));
        wait_done("t5");
        chk("t5_load_count", loads - loads_before, 6);
        chk("t5_no_overflow", {ovf_b, ovf_l}, 2'b00);
        // 6: source ignores byte_ready, overflow is sticky until next start
        out_ready = 1'b0;
        go(16'h0300, 16'd6);
        for (int w = 0; w < 4; w++) expect_word(8'h20 + 8'(2 * w), 8'h21 + 8'(2 * w), 16'h0300 + 16'(w));
        for (int i = 0; i < 12; i++) send_raw(8'h20 + 8'(i));
        chk("t6_overflow_set", {ovf_b, ovf_l}, 2'b11);
        expect_word(8'h30, 8'h31, 16'h0304);
        expect_word(8'h32, 8'h33, 16'h0305);
        out_ready = 1'b1;
        send_honour(8'h30);
        send_honour(8'h31);
        send_honour(8'h32);
        send_honour(8'h33);
        wait_done("t6");
        chk("t6_overflow_sticky", {ovf_b, ovf_l}, 2'b11);
        go(16'h0400, 16'd2);
        chk("t6_overflow_cleared", {ovf_b, ovf_l}, 2'b00);
        expect_word(8'h40, 8'h41, 16'h0400);
        send_honour(8'h40);
        send_honour(8'h41);
        send_honour(8'h42);
        RST = 1'b1;
        tick();
        chk_zero("t6_reset_mid_transfer");
        chk("t6_loaded_before_reset", q.size(), 0);
        q.delete();
        RST = 1'b0;
        tick();
        go(16'h0500, 16'd1);
        expect_word(8'hAA, 8'hBB, 16'h0500);
        send_honour(8'hAA);
        send_honour(8'hBB);
        wait_done("t6_restart");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
